sha256_msg_sched: RTL and testbench

SHA256_MSG_SCHED -- requirements
Module: sha256_msg_sched

---
 rtl/sha256_msg_sched.sv | 125 ++++++++++++
 tb/tb_sha256_msg_sched.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_msg_sched.sv
// SHA-256 message schedule: a 16-word circular buffer plus a 3-step datapath
// that computes W[t] for rounds 16..63 through one shared 32-bit adder.
module sha256_msg_sched (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        start_new_block,
   input  logic        ctrl_start,
   input  logic        stn,
   input  logic [5:0]  round_t,
   input  logic [31:0] message_word_in,
   input  logic [3:0]  message_word_addr,
   input  logic        write_enable_in,
   output logic [31:0] wt_out,
   output logic        wt_valid
);

   typedef enum logic [1:0] {IDLE, S0, S1, S2} state_t;

   state_t      state;
   logic [31:0] w_mem [16];
   logic [31:0] reg_w;
   logic        pending;
   logic        wt_valid_reg;

   logic [3:0]  t4;
   logic [3:0]  addr_m15;
   logic [3:0]  addr_m7;
   logic [3:0]  addr_m2;
   logic        early;
   logic        go;
   logic        do_wb;
   logic [31:0] add_a;
   logic [31:0] add_b;
   logic [31:0] sum;

   function automatic logic [31:0] sigma0(input logic [31:0] x);
      return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
   endfunction

   function automatic logic [31:0] sigma1(input logic [31:0] x);
      return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
   endfunction

   // Offsets into the 16-entry ring wrap naturally in 4 bits.
   assign t4       = round_t[3:0];
   assign addr_m15 = t4 + 4'd1;
   assign addr_m7  = t4 + 4'd9;
   assign addr_m2  = t4 + 4'd14;
   assign early    = (round_t < 6'd16);
   assign go       = (state == IDLE) && !early && (pending || stn || ctrl_start);

   always_comb begin
      add_a = reg_w;
      add_b = 32'd0;
      case (state)
         S0: begin
            add_a = w_mem[t4];
            add_b = sigma0(w_mem[addr_m15]);
         end
         S1: add_b = w_mem[addr_m7];
         S2: add_b = sigma1(w_mem[addr_m2]);
         default: ;
      endcase
   end

   assign sum = add_a + add_b;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state        <= IDLE;
         pending      <= 1'b0;
         reg_w        <= 32'd0;
         wt_valid_reg <= 1'b0;
      end else if (start_new_block) begin
         state        <= IDLE;
         pending      <= 1'b0;
         wt_valid_reg <= 1'b0;
      end else begin
         if (go)
            pending <= 1'b0;
         else if (stn || ctrl_start)
            pending <= 1'b1;

         // Rounds 0..15 read straight from the buffer; the datapath stays parked.
         if (early) begin
            state <= IDLE;
         end else begin
            case (state)
               IDLE: if (go) begin
                  state        <= S0;
                  wt_valid_reg <= 1'b0;
               end
               S0: begin
                  reg_w <= sum;
                  state <= S1;
               end
               S1: begin
                  reg_w <= sum;
                  state <= S2;
               end
               S2: begin
                  reg_w        <= sum;
                  wt_valid_reg <= 1'b1;
                  state        <= IDLE;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   assign do_wb = (state == S2) && !early && !start_new_block;

   // Buffer has no reset; the external load is written last so it wins a collision.
   always_ff @(posedge clk) begin
      if (do_wb)
         w_mem[t4] <= sum;
      if (write_enable_in)
         w_mem[message_word_addr] <= message_word_in;
   end

   assign wt_out   = early ? w_mem[t4] : reg_w;
   assign wt_valid = early ? 1'b1 : wt_valid_reg;

endmodule

// File: tb/tb_sha256_msg_sched.sv
// Directed bench for sha256_msg_sched: function units, "abc" schedule,
// pending handling, block abort and mid-computation reset.
module tb_sha256_msg_sched;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        start_new_block;
   logic        ctrl_start;
   logic        stn;
   logic [5:0]  round_t;
   logic [31:0] message_word_in;
   logic [3:0]  message_word_addr;
   logic        write_enable_in;
   logic [31:0] wt_out;
   logic        wt_valid;

   int n_chk = 0;
   int n_err = 0;
   logic [31:0] blk [16];

   sha256_msg_sched dut (
      .clk               (clk),
      .reset_n           (reset_n),
      .start_new_block   (start_new_block),
      .ctrl_start        (ctrl_start),
      .stn               (stn),
      .round_t           (round_t),
      .message_word_in   (message_word_in),
      .message_word_addr (message_word_addr),
      .write_enable_in   (write_enable_in),
      .wt_out            (wt_out),
      .wt_valid          (wt_valid)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %08h expected %08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load_blk();
      round_t = 6'd0;
      for (int i = 0; i < 16; i++) begin
         message_word_addr = i[3:0];
         message_word_in   = blk[i];
         write_enable_in   = 1'b1;
         tick();
      end
      write_enable_in = 1'b0;
   endtask

   task automatic set_abc();
      for (int i = 0; i < 16; i++) blk[i] = 32'd0;
      blk[0]  = 32'h61626380;
      blk[15] = 32'h00000018;
   endtask

   // Arms pending from round 0, so round t starts without an stn of its own.
   task automatic arm_at_round0();
      round_t    = 6'd0;
      ctrl_start = 1'b1;
      tick();
      ctrl_start = 1'b0;
      tick();
   endtask

   task automatic sched(input string tag, input logic [5:0] t, input logic use_stn,
                        input logic [31:0] exp);
      round_t = t;
      stn     = use_stn;
      tick();
      stn = 1'b0;
      tick();
      tick();
      chk({tag, "_vld_e3"}, {31'd0, wt_valid}, 32'd0);
      tick();
      chk({tag, "_vld"}, {31'd0, wt_valid}, 32'd1);
      chk(tag, wt_out, exp);
   endtask

   initial begin
      reset_n           = 1'b0;
      start_new_block   = 1'b0;
      ctrl_start        = 1'b0;
      stn               = 1'b0;
      round_t           = 6'd16;
      message_word_in   = 32'd0;
      message_word_addr = 4'd0;
      write_enable_in   = 1'b0;

      #3;
      chk("rst_wt", wt_out, 32'd0);
      chk("rst_vld", {31'd0, wt_valid}, 32'd0);
      tick();
      tick();
      reset_n = 1'b1;
      tick();
      chk("rst_hold_vld", {31'd0, wt_valid}, 32'd0);

      // sigma0(1), entered through pending retained across round 0
      for (int i = 0; i < 16; i++) blk[i] = 32'd0;
      blk[1] = 32'h00000001;
      load_blk();
      arm_at_round0();
      sched("sig0", 6'd16, 1'b0, 32'h02004000);

      // sigma1(1)
      for (int i = 0; i < 16; i++) blk[i] = 32'd0;
      blk[14] = 32'h00000001;
      load_blk();
      sched("sig1", 6'd16, 1'b1, 32'h0000A000);

      // adder wrap, with intermediate sums visible
      for (int i = 0; i < 16; i++) blk[i] = 32'd0;
      blk[0] = 32'hFFFFFFFF;
      blk[9] = 32'h00000001;
      load_blk();
      round_t = 6'd16;
      stn     = 1'b1;
      tick();
      stn = 1'b0;
      tick();
      chk("add_s0", wt_out, 32'hFFFFFFFF);
      chk("add_s0_vld", {31'd0, wt_valid}, 32'd0);
      tick();
      chk("add_s1", wt_out, 32'h00000000);
      tick();
      chk("add_wrap", wt_out, 32'h00000000);
      chk("add_vld", {31'd0, wt_valid}, 32'd1);

      // "abc" block read-back and schedule
      set_abc();
      load_blk();
      for (int i = 0; i < 16; i++) begin
         round_t = i[5:0];
         #1;
         chk("rd_word", wt_out, blk[i]);
         chk("rd_vld", {31'd0, wt_valid}, 32'd1);
      end
      arm_at_round0();
      sched("w16", 6'd16, 1'b1, 32'h61626380);
      sched("w17", 6'd17, 1'b1, 32'h000F0000);
      sched("w18", 6'd18, 1'b1, 32'h7DA86405);
      sched("w19", 6'd19, 1'b1, 32'h600003C6);
      round_t = 6'd0;
      #1;
      chk("slot0", wt_out, 32'h61626380);
      round_t = 6'd1;
      #1;
      chk("slot1", wt_out, 32'h000F0000);

      // stn during S1 is held and serviced on return to IDLE
      load_blk();
      sched("p_w16", 6'd16, 1'b1, 32'h61626380);
      round_t = 6'd17;
      stn     = 1'b1;
      tick();
      stn = 1'b0;
      tick();
      stn = 1'b1;
      tick();
      stn = 1'b0;
      chk("p_vld_s2", {31'd0, wt_valid}, 32'd0);
      tick();
      chk("p_w17_vld", {31'd0, wt_valid}, 32'd1);
      chk("p_w17", wt_out, 32'h000F0000);
      round_t = 6'd18;
      tick();
      chk("p_restart_vld", {31'd0, wt_valid}, 32'd0);
      tick();
      tick();
      tick();
      chk("p_w18_vld", {31'd0, wt_valid}, 32'd1);
      chk("p_w18", wt_out, 32'h7DA86405);

      // start_new_block during S1
      load_blk();
      round_t = 6'd17;
      stn     = 1'b1;
      tick();
      stn = 1'b0;
      tick();
      start_new_block = 1'b1;
      tick();
      start_new_block = 1'b0;
      chk("snb_vld", {31'd0, wt_valid}, 32'd0);
      chk("snb_regw", wt_out, 32'h00000000);
      for (int i = 0; i < 4; i++) tick();
      chk("snb_idle_vld", {31'd0, wt_valid}, 32'd0);
      round_t = 6'd1;
      #1;
      chk("snb_slot1", wt_out, 32'h00000000);
      round_t = 6'd0;
      #1;
      chk("snb_slot0", wt_out, 32'h61626380);

      // reset during S2 of round 17
      round_t = 6'd17;
      stn     = 1'b1;
      tick();
      stn = 1'b0;
      tick();
      tick();
      reset_n = 1'b0;
      #1;
      chk("rs2_wt", wt_out, 32'h00000000);
      chk("rs2_vld", {31'd0, wt_valid}, 32'd0);
      tick();
      reset_n = 1'b1;
      tick();
      chk("rs2_post_vld", {31'd0, wt_valid}, 32'd0);
      round_t = 6'd1;
      #1;
      chk("rs2_slot1", wt_out, 32'h00000000);
      round_t = 6'd15;
      #1;
      chk("rs2_slot15", wt_out, 32'h00000018);
      sched("rs2_w17", 6'd17, 1'b1, 32'h000F0000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
      $finish;
   end

endmodule
